// File: rtl/cam_deserializer.sv
// Camera-port nibble link receiver: oversamples cam_pclk/cam_sync/cam_data and rebuilds 32-bit words.
// Define CAM_DROP_IDLE_EN to suppress delivery of the 32'hDEADBEEF idle filler word.
module cam_deserializer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned ERR_WIDTH      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n,
   input  logic                 cam_pclk,
   input  logic                 cam_sync,
   input  logic [3:0]           cam_data,
   output logic [31:0]          data_o,
   output logic                 valid_o,
   output logic                 link_up_o,
   output logic                 err_o,
   output logic [ERR_WIDTH-1:0] err_count_o
);

   localparam int unsigned      IdleW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYCLES);

   logic                 pclk_s1_q, pclk_s2_q, pclk_s3_q;
   logic                 sync_s1_q, sync_s2_q;
   logic [3:0]           data_s1_q, data_s2_q;
   logic                 rise;

   logic                 locked_q, locked_d;
   logic [2:0]           idx_q, idx_d;
   logic [31:0]          shift_q, shift_d;
   logic [IdleW-1:0]     idle_q, idle_d;
   logic [31:0]          data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 link_up_q, link_up_d;
   logic                 err_q, err_d;
   logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                 err_inc;
   logic [31:0]          word;

   assign rise = pclk_s2_q & ~pclk_s3_q;
   assign word = {data_s2_q, shift_q[27:0]};

   always_comb begin
      locked_d  = locked_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      idle_d    = idle_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      link_up_d = link_up_q;
      err_inc   = 1'b0;
      if (rise) begin
         idle_d = '0;
         if (sync_s2_q) begin
            // A sync inside a locked frame aborts it, then starts the new frame.
            if (locked_q && idx_q != 3'd0) err_inc = 1'b1;
            locked_d     = 1'b1;
            shift_d[3:0] = data_s2_q;
            idx_d        = 3'd1;
         end else if (locked_q) begin
            if (idx_q == 3'd0) begin
               err_inc  = 1'b1;
               locked_d = 1'b0;
            end else begin
               shift_d[{idx_q, 2'b00} +: 4] = data_s2_q;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  link_up_d = 1'b1;
`ifdef CAM_DROP_IDLE_EN
                  if (word != 32'hDEADBEEF) begin
                     data_d  = word;
                     valid_d = 1'b1;
                  end
`else
                  data_d  = word;
                  valid_d = 1'b1;
`endif
               end
            end
         end
      end else if (idle_q != IdleMax) begin
         idle_d = idle_q + IdleW'(1);
         if (idle_d == IdleMax) begin
            locked_d  = 1'b0;
            idx_d     = 3'd0;
            link_up_d = 1'b0;
         end
      end
      err_d     = err_inc;
      err_cnt_d = err_cnt_q;
      if (err_inc && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         pclk_s1_q <= 1'b0;
         pclk_s2_q <= 1'b0;
         pclk_s3_q <= 1'b0;
         sync_s1_q <= 1'b0;
         sync_s2_q <= 1'b0;
         data_s1_q <= '0;
         data_s2_q <= '0;
         locked_q  <= 1'b0;
         idx_q     <= '0;
         shift_q   <= '0;
         idle_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         link_up_q <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         pclk_s1_q <= cam_pclk;
         pclk_s2_q <= pclk_s1_q;
         pclk_s3_q <= pclk_s2_q;
         sync_s1_q <= cam_sync;
         sync_s2_q <= sync_s1_q;
         data_s1_q <= cam_data;
         data_s2_q <= data_s1_q;
         locked_q  <= locked_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         idle_q    <= idle_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         link_up_q <= link_up_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign link_up_o   = link_up_q;
   assign err_o       = err_q;
   assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_cam_deserializer.sv
// Randomised bench for cam_deserializer against a frame-level nibble-stream model.
// Honours CAM_DROP_IDLE_EN in the same way as the design.
module tb_cam_deserializer;
   localparam int unsigned TO     = 64;
   localparam int unsigned EW     = 3;
   localparam int unsigned ErrMax = (1 << EW) - 1;

   logic          clk_i    = 1'b0;
   logic          rst_n    = 1'b0;
   logic          cam_pclk = 1'b0;
   logic          cam_sync = 1'b0;
   logic [3:0]    cam_data = 4'h0;
   logic [31:0]   data_o;
   logic          valid_o;
   logic          link_up_o;
   logic          err_o;
   logic [EW-1:0] err_count_o;

   cam_deserializer #(
      .TIMEOUT_CYCLES (TO),
      .ERR_WIDTH      (EW)
   ) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .cam_pclk    (cam_pclk),
      .cam_sync    (cam_sync),
      .cam_data    (cam_data),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .link_up_o   (link_up_o),
      .err_o       (err_o),
      .err_count_o (err_count_o)
   );

   always #5 clk_i = ~clk_i;

   int          checks = 0;
   int          errors = 0;
   // model state: frame-level view of the nibble stream
   bit          m_locked = 1'b0;
   bit          m_link   = 1'b0;
   logic [3:0]  m_nibs[$];
   logic [31:0] exp_words[$];
   int          exp_errs  = 0;
   int          err_seen  = 0;
   logic [31:0] last_word = 32'h0;
   longint      cyc       = 0;
   longint      valid_cyc[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_nib(bit s, logic [3:0] n);
      logic [31:0] w;
      w = 32'h0;
      if (s) begin
         if (m_locked && m_nibs.size() != 0) exp_errs++;
         m_nibs.delete();
         m_nibs.push_back(n);
         m_locked = 1'b1;
      end else if (m_locked) begin
         if (m_nibs.size() == 0) begin
            exp_errs++;
            m_locked = 1'b0;
         end else begin
            m_nibs.push_back(n);
            if (m_nibs.size() == 8) begin
               for (int i = 0; i < 8; i++) w = w | (32'(m_nibs[i]) << (4 * i));
               m_link = 1'b1;
`ifdef CAM_DROP_IDLE_EN
               if (w != 32'hDEADBEEF) exp_words.push_back(w);
`else
               exp_words.push_back(w);
`endif
               m_nibs.delete();
            end
         end
      end
   endfunction

   function automatic void model_reset();
      m_locked  = 1'b0;
      m_link    = 1'b0;
      m_nibs.delete();
      exp_words.delete();
      exp_errs  = 0;
      err_seen  = 0;
      last_word = 32'h0;
   endfunction

   // Compare process: strobes are matched against model events in order.
   always @(negedge clk_i) begin
      cyc++;
      if (rst_n) begin
         if (valid_o) begin
            valid_cyc.push_back(cyc);
            check("valid_o expected", valid_o, exp_words.size() != 0);
            if (exp_words.size() != 0) last_word = exp_words.pop_front();
         end
         if (err_o) begin
            check("err_o expected", err_o, exp_errs != 0);
            if (exp_errs != 0) begin
               exp_errs--;
               err_seen++;
            end
         end
         check("data_o", data_o, last_word);
         check("err_count_o", err_count_o, (err_seen > ErrMax) ? ErrMax : err_seen);
      end
   end

   task automatic wait_cyc(int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic send_nib(bit s, logic [3:0] n, int half);
      cam_pclk = 1'b0;
      cam_sync = s;
      cam_data = n;
      wait_cyc(half);
      cam_pclk = 1'b1;
      model_nib(s, n);
      wait_cyc(half);
   endtask

   task automatic send_word(logic [31:0] w, int half);
      for (int i = 0; i < 8; i++) send_nib(i == 0, w[4*i +: 4], half);
   endtask

   task automatic drain();
      wait_cyc(6);
      check("pending words", exp_words.size(), 0);
      check("pending errs", exp_errs, 0);
      check("link_up_o", link_up_o, m_link);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [31:0] w;
      wait_cyc(3);
      check("reset data_o", data_o, 0);
      check("reset valid_o", valid_o, 0);
      check("reset link_up_o", link_up_o, 0);
      check("reset err_o", err_o, 0);
      check("reset err_count_o", err_count_o, 0);
      rst_n = 1'b1;
      wait_cyc(3);

      // Single word with exact strobe latency on the 8th rise.
      w = 32'hCAFEF00D;
      for (int i = 0; i < 7; i++) send_nib(i == 0, w[4*i +: 4], 8);
      cam_pclk = 1'b0;
      cam_data = w[31:28];
      cam_sync = 1'b0;
      wait_cyc(8);
      cam_pclk = 1'b1;
      model_nib(1'b0, w[31:28]);
      wait_cyc(2);
      check("valid_o before N+2", valid_o, 0);
      wait_cyc(1);
      check("valid_o at N+2", valid_o, 1);
      check("data_o CAFEF00D", data_o, 32'hCAFEF00D);
      wait_cyc(1);
      check("valid_o one cycle", valid_o, 0);
      check("link_up_o after word", link_up_o, 1);
      wait_cyc(4);
      drain();

      // Back-to-back frames, strobes 8 pclk periods (128 clk) apart.
      n0 = valid_cyc.size();
      send_word(32'h12345678, 8);
      send_word(32'h9ABCDEF0, 8);
      drain();
      check("b2b strobe count", valid_cyc.size() - n0, 2);
      if (valid_cyc.size() - n0 == 2)
         check("b2b spacing", valid_cyc[n0+1] - valid_cyc[n0], 128);
      check("b2b data_o", data_o, 32'h9ABCDEF0);
      check("b2b err_count_o", err_count_o, 0);

      // Sync on nibble 4 aborts the partial word and restarts there.
      w = 32'h0BADC0DE;
      for (int i = 0; i < 4; i++) send_nib(i == 0, 4'h7, 6);
      send_word(w, 6);
      drain();
      check("resync data_o", data_o, 32'h0BADC0DE);
      check("resync err_count_o", err_count_o, 1);

      // Ninth nibble without sync: error, then whole word dropped.
      send_nib(1'b0, 4'h5, 6);
      for (int i = 0; i < 8; i++) send_nib(1'b0, 4'(i), 6);
      drain();
      check("nosync err_count_o", err_count_o, 2);
      check("nosync data_o", data_o, 32'h0BADC0DE);

      // Link timeout with pclk stopped.
      wait_cyc(TO / 2);
      check("link_up_o before timeout", link_up_o, 1);
      wait_cyc(TO);
      m_link   = 1'b0;
      m_locked = 1'b0;
      m_nibs.delete();
      check("link_up_o after timeout", link_up_o, 0);
      check("timeout data_o", data_o, 32'h0BADC0DE);
      check("timeout err_count_o", err_count_o, 2);

      // Idle filler handling.
      n0 = valid_cyc.size();
      send_word(32'hDEADBEEF, 5);
      send_word(32'h00000001, 5);
      drain();
`ifdef CAM_DROP_IDLE_EN
      check("idle strobe count", valid_cyc.size() - n0, 1);
`else
      check("idle strobe count", valid_cyc.size() - n0, 2);
`endif
      check("idle data_o", data_o, 32'h00000001);
      check("idle link_up_o", link_up_o, 1);

      // Reset mid-frame, then resynchronise.
      for (int i = 0; i < 3; i++) send_nib(i == 0, 4'hA, 5);
      rst_n    = 1'b0;
      cam_pclk = 1'b0;
      model_reset();
      wait_cyc(2);
      check("midrst data_o", data_o, 0);
      check("midrst link_up_o", link_up_o, 0);
      check("midrst err_count_o", err_count_o, 0);
      check("midrst valid_o", valid_o, 0);
      rst_n = 1'b1;
      wait_cyc(3);
      send_word(32'h5A5A1234, 4);
      drain();
      check("post-reset data_o", data_o, 32'h5A5A1234);

      // Random traffic with aborted frames, missing syncs and idle words.
      for (int f = 0; f < 150; f++) begin
         int half;
         int mode;
         half = $urandom_range(4, 10);
         mode = $urandom_range(0, 9);
         w    = ($urandom_range(0, 9) == 0) ? 32'hDEADBEEF : 32'($urandom);
         if (mode == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 7)); i++)
               send_nib(i == 0, 4'($urandom), half);
         end else if (mode == 1) begin
            send_nib(1'b0, 4'($urandom), half);
            send_word(w, half);
         end else begin
            send_word(w, half);
         end
      end
      send_word(32'h600DF00D, 6);
      drain();
      check("final data_o", data_o, 32'h600DF00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cam_deserializer.md
# cam_deserializer

Receive-side counterpart of the ESP32 camera-port nibble link. The block oversamples `cam_pclk`, `cam_sync` and `cam_data[3:0]` in the `clk_i` domain and reassembles 8-nibble frames, least significant nibble first, into 32-bit words. It detects framing errors and link loss, and presents each word as a one-cycle `valid_o` strobe to downstream logic such as a register-file or FIFO writer.

## Interface
- `TIMEOUT_CYCLES`, default 1024: number of `clk_i` cycles without a `cam_pclk` rising edge before the link is declared down. Minimum value is 4.
- `ERR_WIDTH`, default 16: width of the saturating error counter.

Ports:
- `clk_i` input 1: system clock. It must run at least 8× faster than `cam_pclk`.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cam_pclk` input 1: link clock, asynchronous to `clk_i`. Data changes on its falling edge.
- `cam_sync` input 1: high during nibble 0 of each frame.
- `cam_data` input 4: nibble data.
- `data_o` output 32: last completed word.
- `valid_o` output 1: one-cycle strobe indicating `data_o` was updated.
- `link_up_o` output 1: a full frame has been received and no timeout has occurred since.
- `err_o` output 1: one-cycle strobe on a framing error.
- `err_count_o` output `ERR_WIDTH`: saturating count of framing errors.

## Operation
- **Synchronizers.** `cam_pclk`, `cam_sync` and `cam_data` each pass through two flops, giving s1 and s2. `cam_pclk` gets a third flop, s3.
  - Rising-edge event `rise` = s2 & ~s3.
  - All sampling happens only on `rise`, using the s2 copies of sync and data.
- **State.**
  - `locked`: 1 bit.
  - `idx`: 3 bits, the next nibble position.
  - `shift`: 32-bit assembly register.
  - `idle_cnt`: counts `clk_i` cycles since the last `rise`.
- **On `rise`, with `sync` = s2 `cam_sync` and `nib` = s2 `cam_data`:**
  - `sync`=1 while `idx`≠0 and `locked`=1: framing error. Pulse `err_o` and increment `err_count_o`. The partial word is discarded. Then apply the next rule.
  - `sync`=1: set `locked`=1, `shift[3:0]`=`nib`, `idx`=1.
  - `sync`=0 and `locked`=0: discard the nibble; no error.
  - `sync`=0, `locked`=1, `idx`=0: framing error (missing sync). Pulse `err_o`, increment `err_count_o`, clear `locked`, discard the nibble.
  - `sync`=0, `locked`=1, `idx`=k in 1..7: `shift[4k+3:4k]`=`nib`, then `idx`=k+1 (mod 8).
  - When k=7: load `data_o` with the assembled word (nibble 7 in [31:28]), pulse `valid_o`, set `link_up_o`=1, and set `idx`=0.
- **Link timeout.** `idle_cnt` resets to 0 on `rise`, otherwise increments and saturates at `TIMEOUT_CYCLES`. When it reaches `TIMEOUT_CYCLES`:
  - clear `locked`, `idx` and `link_up_o`;
  - no error is counted;
  - `data_o` holds its value.
- **Error counter.** `err_count_o` saturates at all-ones and never wraps.
- **Simultaneous events.** A timeout and a `rise` cannot coincide, because `rise` clears the counter first.

## Timing
- **Reset values** (asynchronous, in every flop): `data_o`=0, `valid_o`=0, `link_up_o`=0, `err_o`=0, `err_count_o`=0, `locked`=0, `idx`=0, `idle_cnt`=0, all synchronizers 0.
- **Latency.**
  - If s1 first captures `cam_pclk`=1 at `clk_i` edge N, then s2 changes at N+1, and the `rise` sample and all state/output registers update at edge N+2.
  - `valid_o` and `err_o` are therefore high for exactly the cycle after N+2.
- **Data stability.** Data is stable for half a `cam_pclk` period, at least 4 `clk_i` cycles, around the rising edge, so s2 data at N+2 is valid.
- **No backpressure.** `valid_o` is a strobe. The consumer must accept it; the next word cannot complete sooner than 8 `cam_pclk` periods later.
- **Reset mid-frame.** The partial word is lost. The block resynchronizes on the next `cam_sync`.

## Configuration
- `CAM_DROP_IDLE_EN`
  - Defined: a completed word equal to 32'hDEADBEEF (the transmitter idle filler) does not update `data_o` and does not pulse `valid_o`. `link_up_o` is still set.
  - Undefined: every completed word, including DEADBEEF, is delivered.

## Test plan
- **Reset check.** Assert `rst_n`=0 mid-frame, then release. All outputs must be 0. The first frame after a `cam_sync` must be delivered correctly.
- **Single word.** Drive 0xCAFEF00D, nibbles D,0,0,F,E,F,A,C, with `cam_pclk` half-period 8 `clk_i` cycles. Expect `data_o`=0xCAFEF00D, `valid_o` high for 1 cycle at N+2 after the 8th rise, and `link_up_o`=1.
- **Back-to-back frames.** Send 0x12345678 then 0x9ABCDEF0. Expect two strobes 8 `cam_pclk` periods apart, with correct words and `err_count_o`=0.
- **Sync mid-frame.** Assert `cam_sync` on nibble 4. Expect `err_o` pulse, `err_count_o`=1, no `valid_o` for the aborted word, and the new frame starting at that nibble delivered correctly.
- **Missing sync and timeout.**
  - Send a 9th nibble without sync: expect `err_count_o` to increment and the next word to be dropped until `cam_sync`.
  - Stop `cam_pclk` for `TIMEOUT_CYCLES` cycles: `link_up_o` falls to 0 and `data_o` is unchanged.
- **Idle filter.** Send 0xDEADBEEF then 0x00000001.
  - With `CAM_DROP_IDLE_EN`: one strobe, `data_o`=1.
  - Without it: two strobes.
